// File: rtl/spike_aer_encoder_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | spike_aer_encoder_pkg                                                 |
// | Neuron-tile constants and the AER event word shared by codec blocks.  |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
package spike_aer_encoder_pkg;

   localparam int C_N_NEURONS = 8;
   localparam int C_TS_WIDTH  = 8;
   localparam int C_ADDR_W    = (C_N_NEURONS > 1) ? $clog2(C_N_NEURONS) : 1;

   typedef struct packed {
      logic [C_ADDR_W-1:0]   addr;
      logic [C_TS_WIDTH-1:0] ts;
   } aer_event_t;

endpackage
`default_nettype wire

// File: rtl/spike_aer_encoder_lsb.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | aer_lsb_priority_encoder                                              |
// | Combinational lowest-set-bit index plus any-set flag for a mask.      |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module aer_lsb_priority_encoder
   import spike_aer_encoder_pkg::*;
#(
   parameter int WIDTH  = C_N_NEURONS,
   parameter int ADDR_W = C_ADDR_W
) (
   input  logic [WIDTH-1:0]  mask,
   output logic [ADDR_W-1:0] index,
   output logic              any_set
);

   // Scanning downward lets the lowest set bit overwrite any higher ones.
   always_comb begin
      index   = '0;
      any_set = |mask;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (mask[i]) index = ADDR_W'(i);
      end
   end

endmodule
`default_nettype wire

// File: rtl/spike_aer_encoder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | spike_aer_encoder                                                     |
// | Serialises per-timestep spike snapshots into AER words (addr, stamp). |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module spike_aer_encoder
   import spike_aer_encoder_pkg::*;
#(
   parameter  int N_NEURONS  = C_N_NEURONS,
   parameter  int TS_WIDTH   = C_TS_WIDTH,
   parameter  int DROP_WIDTH = 8,
   localparam int ADDR_W     = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ena,
   input  logic [N_NEURONS-1:0]  spikes_in,
   input  logic                  step_strobe,
   output logic                  aer_valid,
   input  logic                  aer_ready,
   output logic [ADDR_W-1:0]     aer_addr,
   output logic [TS_WIDTH-1:0]   aer_ts,
   output logic                  busy,
   output logic [DROP_WIDTH-1:0] drop_count
);

   logic [TS_WIDTH-1:0]   r_ts_cnt;
   logic [N_NEURONS-1:0]  r_a_mask;
   logic [TS_WIDTH-1:0]   r_a_ts;
   logic [N_NEURONS-1:0]  r_s_mask;
   logic [TS_WIDTH-1:0]   r_s_ts;
   logic [DROP_WIDTH-1:0] r_drop;
   logic                  r_valid;
   logic [ADDR_W-1:0]     r_addr;
   logic                  r_busy;

   logic                  w_acc;
   logic                  w_hs;
   logic                  w_snap;
   logic                  w_promote;
   logic [N_NEURONS-1:0]  w_clear;
   logic [N_NEURONS-1:0]  w_a_after;
   logic [N_NEURONS-1:0]  w_a_mid;
   logic [TS_WIDTH-1:0]   w_a_ts_mid;
   logic [N_NEURONS-1:0]  w_s_mid;
   logic [N_NEURONS-1:0]  w_a_next;
   logic [TS_WIDTH-1:0]   w_a_ts_next;
   logic [N_NEURONS-1:0]  w_s_next;
   logic [TS_WIDTH-1:0]   w_s_ts_next;
   logic                  w_drop_inc;
   logic [ADDR_W-1:0]     w_next_addr;
   logic                  w_next_any;

   assign w_acc  = step_strobe & ena;
   assign w_hs   = r_valid & aer_ready;
   assign w_snap = w_acc & (|spikes_in);

   always_comb begin
      w_clear = '0;
      if (w_hs) w_clear[r_addr] = 1'b1;
      w_a_after = r_a_mask & ~w_clear;

      // Shadow moves up only once the active snapshot has fully drained.
      w_promote  = (w_a_after == '0) && (r_s_mask != '0);
      w_a_mid    = w_promote ? r_s_mask : w_a_after;
      w_a_ts_mid = w_promote ? r_s_ts   : r_a_ts;
      w_s_mid    = w_promote ? '0       : r_s_mask;

      w_a_next    = w_a_mid;
      w_a_ts_next = w_a_ts_mid;
      w_s_next    = w_s_mid;
      w_s_ts_next = r_s_ts;
      w_drop_inc  = 1'b0;
      if (w_snap) begin
         if (w_a_mid == '0) begin
            w_a_next    = spikes_in;
            w_a_ts_next = r_ts_cnt;
         end else if (w_s_mid == '0) begin
            w_s_next    = spikes_in;
            w_s_ts_next = r_ts_cnt;
         end else begin
            w_drop_inc  = 1'b1;
         end
      end
   end

   // Encoding the next-state mask lets the address be registered one cycle early.
   aer_lsb_priority_encoder #(
      .WIDTH  (N_NEURONS),
      .ADDR_W (ADDR_W)
   ) u_lsb (
      .mask    (w_a_next),
      .index   (w_next_addr),
      .any_set (w_next_any)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ts_cnt <= '0;
         r_a_mask <= '0;
         r_a_ts   <= '0;
         r_s_mask <= '0;
         r_s_ts   <= '0;
         r_drop   <= '0;
         r_valid  <= 1'b0;
         r_addr   <= '0;
         r_busy   <= 1'b0;
      end else begin
         if (w_acc) r_ts_cnt <= r_ts_cnt + 1'b1;
         r_a_mask <= w_a_next;
         r_a_ts   <= w_a_ts_next;
         r_s_mask <= w_s_next;
         r_s_ts   <= w_s_ts_next;
         if (w_drop_inc && (r_drop != {DROP_WIDTH{1'b1}})) r_drop <= r_drop + 1'b1;
         r_valid  <= w_next_any;
         r_addr   <= w_next_addr;
         r_busy   <= (|w_a_next) | (|w_s_next);
      end
   end

   assign aer_valid  = r_valid;
   assign aer_addr   = r_addr;
   assign aer_ts     = r_a_ts;
   assign busy       = r_busy;
   assign drop_count = r_drop;

endmodule
`default_nettype wire
